branch_pred_btb: RTL and testbench

//  Parametrised dynamic branch predictor for the FE stage. Replaces the static predict-not-taken

---
 rtl/branch_pred_btb_if.sv | 32 +++
 rtl/branch_pred_btb.sv | 110 +++++++++++
 tb/tb_branch_pred_btb.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/branch_pred_btb_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_pred_btb_if
//  Purpose  : FE lookup / EX update / debug-stat bundle for branch_pred_btb.
//  Revision : 1.0  initial release
// ============================================================================
interface branch_pred_btb_if #(
    parameter int DBITS    = 32,
    parameter int STATBITS = 16
);
    logic [DBITS-1:0]    pc_fe;
    logic [DBITS-1:0]    pcpred_fe;
    logic                predtaken_fe;
    logic                upd_valid;
    logic [DBITS-1:0]    upd_pc;
    logic                upd_taken;
    logic [DBITS-1:0]    upd_target;
    logic                upd_mispred;
    logic                stat_clr;
    logic [STATBITS-1:0] mispred_cnt;

    modport master (
        output pc_fe, upd_valid, upd_pc, upd_taken, upd_target, upd_mispred, stat_clr,
        input  pcpred_fe, predtaken_fe, mispred_cnt
    );

    modport slave (
        input  pc_fe, upd_valid, upd_pc, upd_taken, upd_target, upd_mispred, stat_clr,
        output pcpred_fe, predtaken_fe, mispred_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_pred_btb.sv
`default_nettype none
// ============================================================================
//  Module   : branch_pred_btb
//  Purpose  : Direct-mapped BTB with saturating counters and mispredict stat.
//  Revision : 1.0  initial release
// ============================================================================
module branch_pred_btb #(
    parameter int DBITS    = 32,
    parameter int IDXBITS  = 4,
    parameter int CTRBITS  = 2,
    parameter int STATBITS = 16,
    parameter int INSTSIZE = 4
) (
    input wire               clk,
    input wire               reset_n,
    branch_pred_btb_if.slave bus
);
    localparam int c_ENTRIES = 1 << IDXBITS;
    localparam int c_TAGBITS = DBITS - IDXBITS - 2;

    localparam logic [CTRBITS-1:0]  c_CTR_MAX  = {CTRBITS{1'b1}};
    localparam logic [CTRBITS-1:0]  c_CTR_WEAK = CTRBITS'(1) << (CTRBITS - 1);
    localparam logic [STATBITS-1:0] c_STAT_MAX = {STATBITS{1'b1}};
    localparam logic [DBITS-1:0]    c_INC      = DBITS'(INSTSIZE);

    // Only valid bits carry reset; tag/target/ctr are gated by valid.
    logic [c_ENTRIES-1:0] r_valid;
    logic [c_TAGBITS-1:0] r_tag    [c_ENTRIES];
    logic [DBITS-1:0]     r_target [c_ENTRIES];
    logic [CTRBITS-1:0]   r_ctr    [c_ENTRIES];
    logic [STATBITS-1:0]  r_mispred_cnt;

    logic [IDXBITS-1:0]   w_fe_idx;
    logic [c_TAGBITS-1:0] w_fe_tag;
    logic                 w_fe_hit;
    logic                 w_fe_taken;

    logic [IDXBITS-1:0]   w_up_idx;
    logic [c_TAGBITS-1:0] w_up_tag;
    logic                 w_up_hit;
    logic [CTRBITS-1:0]   w_up_ctr;
    logic [CTRBITS-1:0]   w_up_ctr_next;
    logic                 w_unused;

    assign w_unused = ^{bus.pc_fe[1:0], bus.upd_pc[1:0]};

    // Lookup path
    assign w_fe_idx   = bus.pc_fe[IDXBITS+1:2];
    assign w_fe_tag   = bus.pc_fe[DBITS-1:IDXBITS+2];
    assign w_fe_hit   = r_valid[w_fe_idx] && (r_tag[w_fe_idx] == w_fe_tag);
    assign w_fe_taken = w_fe_hit && r_ctr[w_fe_idx][CTRBITS-1];

    assign bus.predtaken_fe = w_fe_taken;
    assign bus.pcpred_fe    = w_fe_taken ? r_target[w_fe_idx] : (bus.pc_fe + c_INC);
    assign bus.mispred_cnt  = r_mispred_cnt;

    // Update path
    assign w_up_idx = bus.upd_pc[IDXBITS+1:2];
    assign w_up_tag = bus.upd_pc[DBITS-1:IDXBITS+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_ctr = r_ctr[w_up_idx];

    always_comb begin
        w_up_ctr_next = w_up_ctr;
        if (bus.upd_taken) begin
            if (w_up_ctr != c_CTR_MAX) begin
                w_up_ctr_next = w_up_ctr + CTRBITS'(1);
            end
        end else begin
            if (w_up_ctr != '0) begin
                w_up_ctr_next = w_up_ctr - CTRBITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (bus.upd_valid && !w_up_hit && bus.upd_taken) begin
            r_valid[w_up_idx] <= 1'b1;
        end
    end

    // A write landing during reset is harmless: its valid bit stays cleared.
    always_ff @(posedge clk) begin
        if (bus.upd_valid) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= w_up_ctr_next;
                if (bus.upd_taken) begin
                    r_target[w_up_idx] <= bus.upd_target;
                end
            end else if (bus.upd_taken) begin
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= bus.upd_target;
                r_ctr[w_up_idx]    <= c_CTR_WEAK;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mispred_cnt <= '0;
        end else if (bus.stat_clr) begin
            r_mispred_cnt <= '0;
        end else if (bus.upd_valid && bus.upd_mispred && (r_mispred_cnt != c_STAT_MAX)) begin
            r_mispred_cnt <= r_mispred_cnt + STATBITS'(1);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_branch_pred_btb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_pred_btb
//  Purpose  : Directed vector bench for branch_pred_btb (IDXBITS=4, STATBITS=2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_pred_btb;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    branch_pred_btb_if #(.DBITS(32), .STATBITS(2)) bus ();

    branch_pred_btb #(
        .DBITS(32), .IDXBITS(4), .CTRBITS(2), .STATBITS(2), .INSTSIZE(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        um;
        logic        clr;
        logic [31:0] e_pred;
        logic        e_pt;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic um,
                       input logic clr, input logic [31:0] e_pred, input logic e_pt,
                       input logic [1:0] e_cnt);
        vec_t v;
        v.pc = pc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.um = um;
        v.clr = clr; v.e_pred = e_pred; v.e_pt = e_pt; v.e_cnt = e_cnt;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.pc_fe       = v.pc;
        bus.upd_valid   = v.uv;
        bus.upd_pc      = v.upc;
        bus.upd_taken   = v.ut;
        bus.upd_target  = v.utgt;
        bus.upd_mispred = v.um;
        bus.stat_clr    = v.clr;
    endtask

    task automatic idle(input logic [31:0] pc);
        bus.pc_fe       = pc;
        bus.upd_valid   = 1'b0;
        bus.upd_pc      = 32'h0;
        bus.upd_taken   = 1'b0;
        bus.upd_target  = 32'h0;
        bus.upd_mispred = 1'b0;
        bus.stat_clr    = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_n = 1'b0;
        idle(32'h100);

        // pc, uv, upc, ut, tgt, um, clr | exp pcpred, exp taken, exp cnt (pre-edge)
        add(32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 32'h104, 0, 2'd0);
        add(32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 32'h104, 0, 2'd0); // alloc, same cycle
        add(32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 32'h200, 1, 2'd0);
        add(32'h100, 1, 32'h100, 0, 32'h0,   0, 0, 32'h200, 1, 2'd0); // 2->1
        add(32'h100, 1, 32'h100, 0, 32'h0,   0, 0, 32'h104, 0, 2'd0); // 1->0
        add(32'h100, 1, 32'h100, 0, 32'h0,   0, 0, 32'h104, 0, 2'd0); // holds 0
        add(32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 32'h104, 0, 2'd0); // 0->1
        add(32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 32'h104, 0, 2'd0); // 1->2
        add(32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 32'h200, 1, 2'd0);
        add(32'h140, 0, 32'h0,   0, 32'h0,   0, 0, 32'h144, 0, 2'd0); // alias miss
        add(32'h140, 1, 32'h140, 1, 32'h300, 0, 0, 32'h144, 0, 2'd0);
        add(32'h140, 0, 32'h0,   0, 32'h0,   0, 0, 32'h300, 1, 2'd0);
        add(32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 32'h104, 0, 2'd0); // evicted
        add(32'h500, 1, 32'h500, 0, 32'h0,   1, 0, 32'h504, 0, 2'd0); // miss NT: no alloc
        add(32'h500, 1, 32'h500, 0, 32'h0,   1, 0, 32'h504, 0, 2'd1);
        add(32'h500, 1, 32'h500, 0, 32'h0,   1, 0, 32'h504, 0, 2'd2);
        add(32'h500, 1, 32'h500, 0, 32'h0,   1, 0, 32'h504, 0, 2'd3); // saturates
        add(32'h500, 0, 32'h0,   0, 32'h0,   0, 0, 32'h504, 0, 2'd3);
        add(32'h500, 1, 32'h500, 0, 32'h0,   1, 1, 32'h504, 0, 2'd3); // clear wins
        add(32'h500, 0, 32'h0,   0, 32'h0,   0, 0, 32'h504, 0, 2'd0);
        add(32'h600, 0, 32'h600, 1, 32'h700, 1, 0, 32'h604, 0, 2'd0); // upd_valid=0
        add(32'h600, 0, 32'h0,   0, 32'h0,   0, 0, 32'h604, 0, 2'd0);
        add(32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0000_0000, 0, 2'd0); // wrap
        add(32'h140, 1, 32'h140, 1, 32'h340, 0, 0, 32'h300, 1, 2'd0); // 2->3, new target
        add(32'h140, 1, 32'h140, 1, 32'h340, 0, 0, 32'h340, 1, 2'd0); // holds 3
        add(32'h140, 1, 32'h140, 0, 32'h0,   0, 0, 32'h340, 1, 2'd0); // 3->2
        add(32'h140, 1, 32'h140, 0, 32'h0,   0, 0, 32'h340, 1, 2'd0); // 2->1
        add(32'h140, 0, 32'h0,   0, 32'h0,   0, 0, 32'h144, 0, 2'd0);

        #1;
        check("reset_pcpred", bus.pcpred_fe, 32'h104);
        check("reset_predtaken", {31'b0, bus.predtaken_fe}, 32'h0);
        check("reset_cnt", {30'b0, bus.mispred_cnt}, 32'h0);
        #11 reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            #3;
            check($sformatf("v%0d_pcpred", i), bus.pcpred_fe, vq[i].e_pred);
            check($sformatf("v%0d_taken", i), {31'b0, bus.predtaken_fe}, {31'b0, vq[i].e_pt});
            check($sformatf("v%0d_cnt", i), {30'b0, bus.mispred_cnt}, {30'b0, vq[i].e_cnt});
            @(posedge clk); #1;
        end

        // Re-allocate 0x100 and count one mispredict, then pulse reset mid-cycle.
        bus.pc_fe = 32'h100; bus.upd_valid = 1'b1; bus.upd_pc = 32'h100;
        bus.upd_taken = 1'b1; bus.upd_target = 32'h200; bus.upd_mispred = 1'b1;
        bus.stat_clr = 1'b0;
        @(posedge clk); #1;
        idle(32'h100);
        #1;
        check("realloc_pcpred", bus.pcpred_fe, 32'h200);
        check("realloc_cnt", {30'b0, bus.mispred_cnt}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("async_rst_pcpred", bus.pcpred_fe, 32'h104);
        check("async_rst_taken", {31'b0, bus.predtaken_fe}, 32'h0);
        check("async_rst_cnt", {30'b0, bus.mispred_cnt}, 32'h0);

        // Update presented while reset is held must be discarded.
        bus.pc_fe = 32'h180; bus.upd_valid = 1'b1; bus.upd_pc = 32'h180;
        bus.upd_taken = 1'b1; bus.upd_target = 32'h280; bus.upd_mispred = 1'b1;
        @(posedge clk); #1;
        idle(32'h180);
        #1;
        check("rst_upd_discard", bus.pcpred_fe, 32'h184);
        check("rst_upd_cnt", {30'b0, bus.mispred_cnt}, 32'h0);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_miss", bus.pcpred_fe, 32'h184);

        bus.upd_valid = 1'b1; bus.upd_pc = 32'h180; bus.upd_taken = 1'b1;
        bus.upd_target = 32'h280;
        @(posedge clk); #1;
        idle(32'h180);
        #1;
        check("resume_pcpred", bus.pcpred_fe, 32'h280);
        check("resume_taken", {31'b0, bus.predtaken_fe}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
